// File: rtl/cnn_conv_core_pipe.sv
// cnn_conv_core_pipe: conv-layer output core. For each accepted CI x KY x KX window it
// forms CO dot products against static weights, adds a per-channel bias, applies ReLU,
// shifts right by SHIFT and narrows each channel to OBW bits.
// Four-stage valid/ready pipeline (products, per-channel tap sums, channel sum + bias,
// ReLU/requantise). It stalls as a whole whenever the output is held.
// Optional build macro CNN_CONV_CORE_SAT_EN: when defined, channels saturate at 2^OBW-1.
// When it is undefined, channels are truncated to OBW bits and wrap.
module cnn_conv_core_pipe #(
    parameter int CI    = 3,
    parameter int CO    = 3,
    parameter int KX    = 5,
    parameter int KY    = 5,
    parameter int IBW   = 8,
    parameter int WBW   = 7,
    parameter int BBW   = 16,
    parameter int OBW   = 16,
    parameter int SHIFT = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        i_in_valid,
    output logic                        i_in_ready,
    input  logic [CI*KY*KX*IBW-1:0]     i_in_fmap,
    input  logic [CO*CI*KY*KX*WBW-1:0]  i_weight,
    input  logic [CO*BBW-1:0]           i_bias,
    output logic                        o_ot_valid,
    input  logic                        o_ot_ready,
    output logic [CO*OBW-1:0]           o_ot_fmap
);

    localparam int NTAP   = KY * KX;
    localparam int PBW    = IBW + WBW + 1;
    localparam int ACC_BW = PBW + $clog2(CI * KX * KY) + 1;
    localparam int NPROD  = CO * CI * NTAP;
    localparam int QW     = (ACC_BW > OBW) ? ACC_BW : OBW;

    logic                     en;
    logic                     s1_valid, s2_valid, s3_valid;
    logic signed [PBW-1:0]    s1_prod [NPROD];
    logic signed [ACC_BW-1:0] s2_sum  [CO*CI];
    logic signed [ACC_BW-1:0] s3_acc  [CO];

    logic signed [PBW-1:0]    prod_d  [NPROD];
    logic signed [ACC_BW-1:0] sum_d   [CO*CI];
    logic signed [ACC_BW-1:0] acc_d   [CO];
    logic [CO*OBW-1:0]        fmap_d;
    logic [ACC_BW-1:0]        relu;
    logic [QW-1:0]            q;

    // The whole pipeline moves together. It freezes only while a finished point waits downstream.
    assign en         = !o_ot_valid || o_ot_ready;
    assign i_in_ready = en;

    // S1 products: each pixel is zero-extended, each weight is sign-extended, then they are multiplied.
    always_comb begin
        // NOTE: every combinational output gets a default before the loops, so no latch can be inferred.
        prod_d = '{default: '0};
        for (int co = 0; co < CO; co++) begin
            for (int ci = 0; ci < CI; ci++) begin
                for (int t = 0; t < NTAP; t++) begin
                    prod_d[(co*CI+ci)*NTAP+t] =
                        $signed({{(PBW-IBW){1'b0}}, i_in_fmap[(ci*NTAP+t)*IBW +: IBW]}) *
                        $signed({{(PBW-WBW){i_weight[((co*CI+ci)*NTAP+t)*WBW+WBW-1]}},
                                 i_weight[((co*CI+ci)*NTAP+t)*WBW +: WBW]});
                end
            end
        end
    end

    // S2 sums: for each (co, ci), add up the KY*KX products at full accumulator width.
    always_comb begin
        sum_d = '{default: '0};
        for (int k = 0; k < CO*CI; k++) begin
            for (int t = 0; t < NTAP; t++) begin
                sum_d[k] = sum_d[k] + ACC_BW'(s1_prod[k*NTAP+t]);
            end
        end
    end

    // S3 sums: for each co, add the channel partials and the sign-extended bias.
    always_comb begin
        acc_d = '{default: '0};
        for (int co = 0; co < CO; co++) begin
            acc_d[co] = ACC_BW'($signed(i_bias[co*BBW +: BBW]));
            for (int ci = 0; ci < CI; ci++) begin
                acc_d[co] = acc_d[co] + s2_sum[co*CI+ci];
            end
        end
    end

    // S4: apply ReLU, shift right logically by SHIFT, then narrow to OBW by saturating or truncating.
    always_comb begin
        fmap_d = '0;
        relu   = '0;
        q      = '0;
        for (int co = 0; co < CO; co++) begin
            relu = s3_acc[co][ACC_BW-1] ? '0 : s3_acc[co];
            q    = QW'(relu) >> SHIFT;
`ifdef CNN_CONV_CORE_SAT_EN
            fmap_d[co*OBW +: OBW] = (q > QW'({OBW{1'b1}})) ? {OBW{1'b1}} : OBW'(q);
`else
            fmap_d[co*OBW +: OBW] = OBW'(q);
`endif
        end
    end

    // S1 register: the valid flag and the product array.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: these arrays are pipeline flops, not RAM. They are cleared so a reset leaves no stale data.
            s1_valid <= 1'b0;
            for (int i = 0; i < NPROD; i++) s1_prod[i] <= '0;
        end else if (en) begin
            // NOTE: non-blocking assignments let every stage sample the old value of the stage before it.
            s1_valid <= i_in_valid;
            s1_prod  <= prod_d;
        end
    end

    // S2 register: the valid flag and the per-(co, ci) tap sums.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            for (int i = 0; i < CO*CI; i++) s2_sum[i] <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_sum   <= sum_d;
        end
    end

    // S3 register: the valid flag and the biased per-channel accumulators.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s3_valid <= 1'b0;
            for (int i = 0; i < CO; i++) s3_acc[i] <= '0;
        end else if (en) begin
            s3_valid <= s2_valid;
            s3_acc   <= acc_d;
        end
    end

    // S4 register: the output point, which holds while downstream stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_ot_valid <= 1'b0;
            o_ot_fmap  <= '0;
        end else if (en) begin
            o_ot_valid <= s3_valid;
            o_ot_fmap  <= fmap_d;
        end
    end

endmodule

// File: tb/tb_cnn_conv_core_pipe.sv
// tb_cnn_conv_core_pipe: scoreboard bench for cnn_conv_core_pipe.
// Three instances are used. "A" runs the default configuration. "C" is the default
// configuration with SHIFT=5 and shares A's stimulus. "B" is the small CI=1, CO=2,
// 3x3, IBW=4 configuration. Expected points come from an arithmetic reference model.
// The model is evaluated at accept time and queued. Monitors pop the queue and compare
// whenever an output transfer happens.
module tb_cnn_conv_core_pipe;

    localparam int CI = 3, CO = 3, KX = 5, KY = 5, IBW = 8, WBW = 7, BBW = 16, OBW = 16;
    localparam int NTAP = KX * KY;
    localparam int FMW = CI*NTAP*IBW, WTW = CO*CI*NTAP*WBW, BSW = CO*BBW, OTW = CO*OBW;
    localparam int B_CI = 1, B_CO = 2, B_K = 3, B_IBW = 4, B_NTAP = 9;
    localparam int B_FMW = B_CI*B_NTAP*B_IBW, B_WTW = B_CO*B_CI*B_NTAP*WBW;
    localparam int B_BSW = B_CO*BBW, B_OTW = B_CO*OBW;

    logic clk = 1'b0;
    logic reset_n;
    logic in_valid, in_ready, in_ready_c, ot_valid, ot_valid_c, ot_ready;
    logic [FMW-1:0] in_fmap;
    logic [WTW-1:0] weight;
    logic [BSW-1:0] bias;
    logic [OTW-1:0] ot_fmap, ot_fmap_c;
    logic b_in_valid, b_in_ready, b_ot_valid, b_ot_ready;
    logic [B_FMW-1:0] b_in_fmap;
    logic [B_WTW-1:0] b_weight;
    logic [B_BSW-1:0] b_bias;
    logic [B_OTW-1:0] b_ot_fmap;

    int n_tests = 0, n_fail = 0, cyc = 0, rdy_mode = 0;
    bit lat_chk_en = 0, held = 0;
    logic [OTW-1:0] held_val;

    typedef struct {
        logic [OTW-1:0] exp_a;
        logic [OTW-1:0] exp_c;
        int             cyc;
        bit             lat_chk;
    } sb_t;
    sb_t sb_q[$];
    logic [B_OTW-1:0] sbb_q[$];

    cnn_conv_core_pipe u_dut_a (
        .clk(clk), .reset_n(reset_n), .i_in_valid(in_valid), .i_in_ready(in_ready),
        .i_in_fmap(in_fmap), .i_weight(weight), .i_bias(bias),
        .o_ot_valid(ot_valid), .o_ot_ready(ot_ready), .o_ot_fmap(ot_fmap));

    cnn_conv_core_pipe #(.SHIFT(5)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .i_in_valid(in_valid), .i_in_ready(in_ready_c),
        .i_in_fmap(in_fmap), .i_weight(weight), .i_bias(bias),
        .o_ot_valid(ot_valid_c), .o_ot_ready(ot_ready), .o_ot_fmap(ot_fmap_c));

    cnn_conv_core_pipe #(.CI(B_CI), .CO(B_CO), .KX(B_K), .KY(B_K), .IBW(B_IBW)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .i_in_valid(b_in_valid), .i_in_ready(b_in_ready),
        .i_in_fmap(b_in_fmap), .i_weight(b_weight), .i_bias(b_bias),
        .o_ot_valid(b_ot_valid), .o_ot_ready(b_ot_ready), .o_ot_fmap(b_ot_fmap));

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Reads a w-bit field starting at bit lsb, as an unsigned or two's-complement number.
    function automatic longint field(input logic [2047:0] v, input int lsb, input int w, input bit sgn);
        longint r = 0;
        for (int b = 0; b < w; b++) if (v[lsb+b]) r += longint'(1) << b;
        if (sgn && v[lsb+w-1]) r -= longint'(1) << w;
        return r;
    endfunction

    // Reference result for one output channel: dot product + bias, ReLU, divide by 2^shift, narrow.
    function automatic longint model_chan(input int ci_n, input int ntap, input int ibw, input int shift,
                                          input int co, input logic [2047:0] fm,
                                          input logic [2047:0] wt, input logic [2047:0] bs);
        longint acc = 0;
        longint max_v = (longint'(1) << OBW) - 1;
        for (int ci = 0; ci < ci_n; ci++)
            for (int t = 0; t < ntap; t++)
                acc += field(fm, (ci*ntap+t)*ibw, ibw, 1'b0) *
                       field(wt, ((co*ci_n+ci)*ntap+t)*WBW, WBW, 1'b1);
        acc += field(bs, co*BBW, BBW, 1'b1);
        if (acc < 0) acc = 0;
        acc = acc / (longint'(1) << shift);
`ifdef CNN_CONV_CORE_SAT_EN
        if (acc > max_v) acc = max_v;
`else
        acc = acc % (max_v + 1);
`endif
        return acc;
    endfunction

    function automatic logic [OTW-1:0] model_pt(input int shift);
        logic [OTW-1:0] r = '0;
        longint v;
        for (int co = 0; co < CO; co++) begin
            v = model_chan(CI, NTAP, IBW, shift, co, 2048'(in_fmap), 2048'(weight), 2048'(bias));
            r[co*OBW +: OBW] = v[OBW-1:0];
        end
        return r;
    endfunction

    function automatic logic [B_OTW-1:0] model_pt_b();
        logic [B_OTW-1:0] r = '0;
        longint v;
        for (int co = 0; co < B_CO; co++) begin
            v = model_chan(B_CI, B_NTAP, B_IBW, 0, co, 2048'(b_in_fmap), 2048'(b_weight), 2048'(b_bias));
            r[co*OBW +: OBW] = v[OBW-1:0];
        end
        return r;
    endfunction

    // Scoreboard feed: each accepted window queues its model result.
    always @(negedge clk) begin
        sb_t e;
        if (reset_n && in_valid && in_ready) begin
            e.exp_a = model_pt(0);
            e.exp_c = model_pt(5);
            e.cyc = cyc;
            e.lat_chk = lat_chk_en;
            sb_q.push_back(e);
        end
        if (reset_n && b_in_valid && b_in_ready) sbb_q.push_back(model_pt_b());
    end

    // Monitor for A and C: ready rule, stall stability, in-order data and latency.
    always @(negedge clk) begin
        sb_t e;
        if (!reset_n) begin
            held = 1'b0;
        end else begin
            check("in_ready_rule", in_ready, !(ot_valid && !ot_ready));
            if (held) check("stall_hold", {ot_valid, ot_fmap}, {1'b1, held_val});
            if (ot_valid && ot_ready) begin
                if (sb_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_out: got 0x%0h with nothing expected", ot_fmap);
                end else begin
                    e = sb_q.pop_front();
                    check("out_a", ot_fmap, e.exp_a);
                    check("out_c", {ot_valid_c, ot_fmap_c}, {1'b1, e.exp_c});
                    if (e.lat_chk) check("latency", cyc - e.cyc, 4);
                end
            end
            held = ot_valid && !ot_ready;
            held_val = ot_fmap;
        end
    end

    // Monitor for B.
    always @(negedge clk) begin
        if (reset_n && b_ot_valid && b_ot_ready) begin
            if (sbb_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_out_b: got 0x%0h with nothing expected", b_ot_fmap);
            end else begin
                check("out_b", b_ot_fmap, sbb_q.pop_front());
            end
        end
    end

    // Downstream ready pattern: 0 always 1, 1 the 1-0-0 pattern, 2 random, 3 always 0.
    initial begin
        ot_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: ot_ready = 1'b1;
                1: ot_ready = (cyc % 3 == 0);
                2: ot_ready = ($urandom_range(0, 99) < 60);
                default: ot_ready = 1'b0;
            endcase
        end
    end

    function automatic logic [FMW-1:0] fm_all(input int v);
        logic [FMW-1:0] r;
        for (int i = 0; i < CI*NTAP; i++) r[i*IBW +: IBW] = IBW'(v);
        return r;
    endfunction

    function automatic logic [FMW-1:0] fm_rand();
        logic [FMW-1:0] r;
        for (int i = 0; i < CI*NTAP; i++) r[i*IBW +: IBW] = IBW'($urandom);
        return r;
    endfunction

    task automatic set_wt(input int co, input logic [WBW-1:0] w);
        for (int i = 0; i < CI*NTAP; i++) weight[(co*CI*NTAP+i)*WBW +: WBW] = w;
    endtask

    task automatic send(input logic [FMW-1:0] fm);
        int n = 0;
        bit acc = 0;
        in_fmap = fm;
        in_valid = 1'b1;
        do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; n++;
        end while (!acc && n < 200);
        if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: window not accepted within 200 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [B_FMW-1:0] fm);
        int n = 0;
        bit acc = 0;
        b_in_fmap = fm;
        b_in_valid = 1'b1;
        do begin
            @(negedge clk); acc = b_in_ready;
            @(posedge clk); #1; n++;
        end while (!acc && n < 200);
        if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL send_b_timeout: window not accepted within 200 cycles");
        end
        b_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rdy_mode = 0;
        while ((sb_q.size() > 0 || sbb_q.size() > 0) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        if (sb_q.size() > 0 || sbb_q.size() > 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: %0d/%0d points still outstanding", sb_q.size(), sbb_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [B_FMW-1:0] bfm;
        reset_n = 1'b0;
        in_valid = 1'b0; in_fmap = '0; weight = '0; bias = '0;
        b_in_valid = 1'b0; b_in_fmap = '0; b_weight = '0; b_bias = '0; b_ot_ready = 1'b1;
        repeat (3) @(posedge clk); #1;

        // Values held during reset.
        check("rst_valid", ot_valid, 0);
        check("rst_fmap", ot_fmap, 0);
        check("rst_fmap_c", ot_fmap_c, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_valid_b", b_ot_valid, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases, with ready held high so the 4-cycle latency can be checked.
        lat_chk_en = 1'b1;
        for (int co = 0; co < CO; co++) set_wt(co, 7'd1);
        bias = '0;
        send(fm_all(1));
        drain();
        set_wt(0, 7'h7F); set_wt(1, 7'd1); set_wt(2, 7'd2);
        bias = {16'sd3, -16'sd5, 16'sd10};
        send(fm_all(1));
        drain();
        for (int co = 0; co < CO; co++) set_wt(co, 7'd63);
        bias = '0;
        send(fm_all(255));
        drain();
        lat_chk_en = 1'b0;

        // Back-to-back stream while ready follows the 1-0-0 pattern.
        for (int co = 0; co < CO; co++) set_wt(co, 7'd1);
        rdy_mode = 1;
        for (int k = 1; k <= 8; k++) send(fm_all(k));
        drain();

        // Randomised batches. Weights change only when the pipeline is empty.
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < CO*CI*NTAP; i++) weight[i*WBW +: WBW] = WBW'($urandom);
            for (int co = 0; co < CO; co++) bias[co*BBW +: BBW] = BBW'($urandom);
            rdy_mode = 2;
            for (int n = 0; n < 20; n++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                send(fm_rand());
            end
            drain();
        end

        // Reset asserted while 3 points are in flight and the output is stalled.
        for (int co = 0; co < CO; co++) set_wt(co, 7'd1);
        bias = '0;
        rdy_mode = 3;
        for (int k = 1; k <= 3; k++) send(fm_all(k));
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_valid", ot_valid, 1);
        #2;
        reset_n = 1'b0;
        sb_q.delete();
        #1;
        check("async_rst_valid", ot_valid, 0);
        check("async_rst_fmap", ot_fmap, 0);
        check("async_rst_valid_c", ot_valid_c, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        rdy_mode = 0;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_idle", ot_valid, 0);

        // Small configuration: ch0 random weights, ch1 all -64, input all 15, then random windows.
        for (int i = 0; i < B_NTAP; i++) begin
            b_weight[i*WBW +: WBW] = WBW'($urandom);
            b_weight[(B_NTAP+i)*WBW +: WBW] = 7'h40;
        end
        b_bias = '0;
        for (int i = 0; i < B_NTAP; i++) bfm[i*B_IBW +: B_IBW] = 4'hF;
        send_b(bfm);
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < B_NTAP; i++) bfm[i*B_IBW +: B_IBW] = B_IBW'($urandom);
            send_b(bfm);
        end
        drain();
        for (int i = 0; i < B_CO*B_NTAP; i++) b_weight[i*WBW +: WBW] = WBW'($urandom);
        for (int co = 0; co < B_CO; co++) b_bias[co*BBW +: BBW] = BBW'($urandom_range(0, 400)) - 16'd200;
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < B_NTAP; i++) bfm[i*B_IBW +: B_IBW] = B_IBW'($urandom);
            send_b(bfm);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
